// File: rtl/adc_pll_ctrl_pkg.sv
// Package for the ADC PLL lock controller.
// Holds the state encoding, the default timing constants and the helper that
// sizes the shared sequencing counter.
package adc_pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 65536;
  localparam int DEF_SETTLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES   = 4;
  localparam int DEF_CNT_W         = 8;

  // One counter serves every timed state, so it is sized for the longest
  // window plus one spare bit.
  function automatic int cnt_width(input int lock_timeout,
                                   input int settle_cycles,
                                   input int rst_cycles);
    int m;
    m = lock_timeout;
    if (settle_cycles > m) m = settle_cycles;
    if (rst_cycles > m) m = rst_cycles;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/adc_pll_lock_sync.sv
// Two-flop synchronizer bringing the PLL locked flag into the refclk domain.
// Ports:
//   clk    in  reference clock
//   rst_n  in  asynchronous active-low reset, output clears to 0
//   d      in  asynchronous input
//   q      out synchronized output (two refclk cycles of latency)
module adc_pll_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/adc_pll_lock_ctrl.sv
// Reset sequencer and lock supervisor for the ADC PLL.
// Pulses the PLL reset, qualifies the synchronized lock flag over a settle
// window, releases the ADC-domain reset only on stable lock, retries on lock
// timeout, re-locks after loss of lock and keeps sticky loss-of-lock status.
// Ports:
//   refclk        in   PLL reference clock (only clock)
//   rst_n         in   asynchronous active-low reset
//   locked_async  in   PLL locked flag, asynchronous to refclk
//   relock_req    in   1-cycle pulse, restart the sequence from RESET
//   clr_status    in   1-cycle pulse, clear lol_sticky and lol_count
//   pll_rst       out  PLL reset, active-high
//   ready         out  lock qualified (state RUN)
//   adc_rst_n     out  ADC-domain reset, active-low, equal to ready
//   fail          out  retries exhausted
//   lol_sticky    out  loss of lock seen since last clear
//   lol_count     out  loss-of-lock events, saturating
//   state_o       out  current state encoding
//
// state     | meaning
// RESET     | pll_rst held high for RST_CYCLES
// WAIT_LOCK | PLL released, waiting for locked_s up to LOCK_TIMEOUT cycles
// SETTLE    | locked_s must stay high SETTLE_CYCLES consecutive cycles
// RUN       | lock qualified, ADC reset released
// FAIL      | retries exhausted, PLL held in reset until relock_req
module adc_pll_lock_ctrl
  import adc_pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             locked_async,
  input  logic             relock_req,
  input  logic             clr_status,
  output logic             pll_rst,
  output logic             ready,
  output logic             adc_rst_n,
  output logic             fail,
  output logic             lol_sticky,
  output logic [CNT_W-1:0] lol_count,
  output logic [2:0]       state_o
);

  localparam int TW = cnt_width(LOCK_TIMEOUT, SETTLE_CYCLES, RST_CYCLES);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

  logic locked_s;

  adc_pll_lock_sync u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (locked_async),
    .q     (locked_s)
  );

  state_e           state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [RW-1:0]    retry_inc;
  logic             pll_rst_q, pll_rst_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;
  logic             lol_sticky_q, lol_sticky_d;
  logic [CNT_W-1:0] lol_count_q, lol_count_d;
  logic [CNT_W-1:0] lol_base;
  logic             lol_event;

  assign retry_inc = retry_q + RW'(1);
  assign lol_event = (state_q == ST_RUN) && !locked_s;
  // A clear in the same cycle as a loss of lock applies first, so the event
  // lands on a zeroed count.
  assign lol_base  = clr_status ? '0 : lol_count_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    retry_d      = retry_q;
    lol_sticky_d = clr_status ? 1'b0 : lol_sticky_q;
    lol_count_d  = lol_base;

    if (lol_event) begin
      lol_sticky_d = 1'b1;
      if (!(&lol_base)) lol_count_d = lol_base + CNT_W'(1);
    end

    unique case (state_q)
      ST_RESET: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_RESET;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ST_SETTLE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_RUN;
          retry_d = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!locked_s) state_d = ST_RESET;
      end
      ST_FAIL: begin
        cnt_d = '0;
      end
      default: begin
        state_d = ST_RESET;
        cnt_d   = '0;
      end
    endcase

    // Restart request overrides every transition above; loss-of-lock
    // accounting has already been done and is kept.
    if (relock_req) begin
      state_d = ST_RESET;
      cnt_d   = '0;
      retry_d = '0;
    end

    // Outputs are registered from the next state so they line up with state_q.
    pll_rst_d = (state_d == ST_RESET) || (state_d == ST_FAIL);
    ready_d   = (state_d == ST_RUN);
    fail_d    = (state_d == ST_FAIL);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RESET;
      cnt_q        <= '0;
      retry_q      <= '0;
      pll_rst_q    <= 1'b1;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
      lol_sticky_q <= 1'b0;
      lol_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      pll_rst_q    <= pll_rst_d;
      ready_q      <= ready_d;
      fail_q       <= fail_d;
      lol_sticky_q <= lol_sticky_d;
      lol_count_q  <= lol_count_d;
    end
  end

  assign pll_rst    = pll_rst_q;
  assign ready      = ready_q;
  assign adc_rst_n  = ready_q;
  assign fail       = fail_q;
  assign lol_sticky = lol_sticky_q;
  assign lol_count  = lol_count_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_adc_pll_lock_ctrl.sv
// Bench for adc_pll_lock_ctrl with short timing parameters: directed
// scenarios with fixed expected latencies, a random stimulus phase, and a
// cycle-by-cycle comparison against a time-stamp based reference model.
module tb_adc_pll_lock_ctrl;

  localparam int RST  = 4;
  localparam int LT   = 32;
  localparam int SET  = 8;
  localparam int MAXR = 2;
  localparam int CW   = 8;

  localparam int P_RESET = 0, P_WAIT = 1, P_SETTLE = 2, P_RUN = 3, P_FAIL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          locked_async = 1'b0;
  logic          relock_req = 1'b0;
  logic          clr_status = 1'b0;
  logic          pll_rst, ready, adc_rst_n, fail, lol_sticky;
  logic [CW-1:0] lol_count;
  logic [2:0]    state_o;

  int n_checks = 0;
  int n_errors = 0;
  bit model_en = 1'b0;

  adc_pll_lock_ctrl #(
    .RST_CYCLES    (RST),
    .LOCK_TIMEOUT  (LT),
    .SETTLE_CYCLES (SET),
    .MAX_RETRIES   (MAXR),
    .CNT_W         (CW)
  ) dut (
    .refclk       (clk),
    .rst_n        (rst_n),
    .locked_async (locked_async),
    .relock_req   (relock_req),
    .clr_status   (clr_status),
    .pll_rst      (pll_rst),
    .ready        (ready),
    .adc_rst_n    (adc_rst_n),
    .fail         (fail),
    .lol_sticky   (lol_sticky),
    .lol_count    (lol_count),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: phase plus the edge index at which it was entered; the
  // lock flag seen at edge n is locked_async as sampled at edge n-2.
  int m_phase, m_enter, m_cyc, m_retry, m_lolcnt;
  bit m_sticky, la_h1, la_h2;

  always @(posedge clk or negedge rst_n) begin : ref_model
    int n, spent, nph, nretry, ncnt;
    bit ls, nsticky;
    if (!rst_n) begin
      m_phase  <= P_RESET;
      m_enter  <= 0;
      m_cyc    <= 0;
      m_retry  <= 0;
      m_lolcnt <= 0;
      m_sticky <= 1'b0;
      la_h1    <= 1'b0;
      la_h2    <= 1'b0;
    end else begin
      n       = m_cyc + 1;
      spent   = n - m_enter;
      ls      = la_h2;
      nph     = m_phase;
      nretry  = m_retry;
      ncnt    = clr_status ? 0 : m_lolcnt;
      nsticky = clr_status ? 1'b0 : m_sticky;
      if (m_phase == P_RUN && !ls) begin
        nsticky = 1'b1;
        ncnt    = (ncnt < 255) ? ncnt + 1 : 255;
      end
      if (relock_req) begin
        nph    = P_RESET;
        nretry = 0;
      end else begin
        case (m_phase)
          P_RESET:  if (spent == RST) nph = P_WAIT;
          P_WAIT: begin
            if (ls) nph = P_SETTLE;
            else if (spent == LT) begin
              nretry = nretry + 1;
              nph    = (nretry == MAXR) ? P_FAIL : P_RESET;
            end
          end
          P_SETTLE: begin
            if (!ls) nph = P_WAIT;
            else if (spent == SET) begin
              nph    = P_RUN;
              nretry = 0;
            end
          end
          P_RUN:    if (!ls) nph = P_RESET;
          default:  ;
        endcase
      end
      if (relock_req || nph != m_phase) m_enter <= n;
      m_cyc    <= n;
      m_phase  <= nph;
      m_retry  <= nretry;
      m_lolcnt <= ncnt;
      m_sticky <= nsticky;
      la_h2    <= la_h1;
      la_h1    <= locked_async;
    end
  end

  logic [15:0] dut_vec, mdl_vec;
  assign dut_vec = {state_o, pll_rst, ready, adc_rst_n, fail, lol_sticky, lol_count};
  assign mdl_vec = {3'(m_phase), (m_phase == P_RESET) || (m_phase == P_FAIL),
                    m_phase == P_RUN, m_phase == P_RUN, m_phase == P_FAIL,
                    m_sticky, 8'(m_lolcnt)};

  always @(negedge clk) begin
    if (model_en) chk("model", 32'(dut_vec), 32'(mdl_vec));
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ready(input string tag, input int lim, output int n);
    n = 0;
    while (ready !== 1'b1 && n < lim) begin
      step();
      n++;
    end
    if (ready !== 1'b1) chk({tag, "_timeout"}, 32'(ready), 1);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int lim);
    int n;
    n = 0;
    while (state_o !== s && n < lim) begin
      step();
      n++;
    end
    if (state_o !== s) chk({tag, "_timeout"}, 32'(state_o), 32'(s));
  endtask

  initial begin
    int n, w, pulses;
    bit prev, saw_wait;

    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state_o), P_RESET);
    chk("rst_pll_rst", 32'(pll_rst), 1);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_adc_rst_n", 32'(adc_rst_n), 0);
    chk("rst_fail", 32'(fail), 0);
    chk("rst_lol", 32'({lol_sticky, lol_count}), 0);
    model_en = 1'b1;

    // 1: reset release, lock 10 cycles into WAIT_LOCK
    rst_n = 1'b1;
    n = 0;
    while (pll_rst === 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("t1_pll_rst_width", 32'(n), RST);
    chk("t1_wait_state", 32'(state_o), P_WAIT);
    repeat (10) step();
    locked_async = 1'b1;
    wait_ready("t1_ready", 40, n);
    chk("t1_ready_latency", 32'(n), SET + 3);
    chk("t1_adc_rst_n", 32'(adc_rst_n), 1);
    chk("t1_run_state", 32'(state_o), P_RUN);

    // 2: glitch during SETTLE restarts the window
    relock_req = 1'b1;
    step();
    relock_req = 1'b0;
    chk("t2_relock_state", 32'(state_o), P_RESET);
    chk("t2_relock_no_lol", 32'(lol_count), 0);
    wait_state("t2_settle", 3'(P_SETTLE), 20);
    repeat (5) step();
    locked_async = 1'b0;
    step();
    locked_async = 1'b1;
    n = 0;
    saw_wait = 1'b0;
    while (ready !== 1'b1 && n < 40) begin
      step();
      n++;
      if (state_o == 3'(P_WAIT)) saw_wait = 1'b1;
    end
    chk("t2_back_to_wait", 32'(saw_wait), 1);
    chk("t2_ready_latency", 32'(n), SET + 3);

    // 3: no lock at all -> two reset pulses then FAIL
    locked_async = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n = 0;
    pulses = 1;
    prev = pll_rst;
    while (fail !== 1'b1 && n < 200) begin
      step();
      n++;
      if (pll_rst && !prev && !fail) pulses++;
      prev = pll_rst;
    end
    chk("t3_fail_time", 32'(n), MAXR * (RST + LT));
    chk("t3_pulses", 32'(pulses), MAXR);
    repeat (20) step();
    chk("t3_fail_hold_pll_rst", 32'(pll_rst), 1);
    chk("t3_fail_hold_state", 32'(state_o), P_FAIL);

    // 5a: relock from FAIL
    locked_async = 1'b1;
    relock_req = 1'b1;
    step();
    relock_req = 1'b0;
    chk("t5_relock_state", 32'(state_o), P_RESET);
    chk("t5_relock_fail", 32'(fail), 0);
    wait_ready("t5_ready", 40, n);
    chk("t5_run_state", 32'(state_o), P_RUN);

    // 4: loss of lock in RUN
    locked_async = 1'b0;
    n = 0;
    while (ready !== 1'b0 && n < 10) begin
      step();
      n++;
    end
    chk("t4_ready_drop_latency", 32'(n), 3);
    chk("t4_lol_sticky", 32'(lol_sticky), 1);
    chk("t4_lol_count", 32'(lol_count), 1);
    locked_async = 1'b1;
    w = 1;
    while (w < 20) begin
      step();
      if (pll_rst !== 1'b1) break;
      w++;
    end
    chk("t4_pll_rst_width", 32'(w), RST);
    wait_ready("t4_relock", 40, n);
    chk("t4_run_state", 32'(state_o), P_RUN);

    // 5b: clear coincident with a loss of lock
    locked_async = 1'b0;
    step();
    step();
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    chk("t5_clr_lol_count", 32'(lol_count), 1);
    chk("t5_clr_lol_sticky", 32'(lol_sticky), 1);
    locked_async = 1'b1;
    wait_ready("t5_relock", 40, n);

    // random phase, every cycle compared with the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) locked_async = ~locked_async;
      relock_req = ($urandom_range(0, 63) == 0);
      clr_status = ($urandom_range(0, 63) == 0);
      step();
    end
    relock_req = 1'b0;
    clr_status = 1'b0;

    // 6: async reset mid-SETTLE
    locked_async = 1'b1;
    relock_req = 1'b1;
    step();
    relock_req = 1'b0;
    wait_state("t6_settle", 3'(P_SETTLE), 20);
    step();
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_state", 32'(state_o), P_RESET);
    chk("t6_async_pll_rst", 32'(pll_rst), 1);
    chk("t6_async_ready", 32'({ready, adc_rst_n}), 0);
    chk("t6_async_fail", 32'(fail), 0);
    chk("t6_async_lol", 32'({lol_sticky, lol_count}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // saturate the loss-of-lock counter with random timing
    for (int i = 0; i < 256; i++) begin
      wait_ready("t6_sat_ready", 60, n);
      repeat ($urandom_range(0, 4)) step();
      locked_async = 1'b0;
      repeat ($urandom_range(1, 6)) step();
      locked_async = 1'b1;
      repeat (3) step();
    end
    repeat (5) step();
    chk("t6_sat_count", 32'(lol_count), 255);
    chk("t6_sat_sticky", 32'(lol_sticky), 1);

    model_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
